// File: rtl/envelope_key_ctrl.sv
// Digital-envelope key sequencer: wraps or unwraps a session key through an external
// mod-exp engine chunk by chunk, then requests key expansion. ENVELOPE_ABORT_EN adds an abort input.
module envelope_key_ctrl #(
  parameter int unsigned KEY_W       = 128,
  parameter int unsigned CHUNK_W     = 64,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic                                             clk,
  input  logic                                             rst,
`ifdef ENVELOPE_ABORT_EN
  input  logic                                             abort,
`endif
  input  logic                                             start,
  input  logic                                             mode,
  input  logic [(KEY_W/CHUNK_W)*(CHUNK_W+1)-1:0]           cmkey_in,
  input  logic [KEY_W-1:0]                                 rnd_in,
  output logic [(KEY_W/CHUNK_W)*(CHUNK_W+1)-1:0]           cmkey_out,
  output logic [KEY_W-1:0]                                 mkey,
  output logic                                             dir,
  output logic                                             busy,
  output logic                                             ready,
  output logic                                             err,
  output logic [1:0]                                       rsa_cmd,
  output logic [CHUNK_W:0]                                 rsa_msg,
  input  logic [CHUNK_W:0]                                 rsa_res,
  input  logic                                             rsa_rsp,
  output logic                                             kx_start,
  input  logic                                             kx_done
);

  localparam int unsigned NCHUNK   = KEY_W / CHUNK_W;
  localparam int unsigned CW       = NCHUNK * (CHUNK_W + 1);
  localparam int unsigned IW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  if ((KEY_W % CHUNK_W) != 0) begin : g_bad_cfg
    $error("envelope_key_ctrl: KEY_W must be a multiple of CHUNK_W");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RSA_REQ, S_RSA_WAIT, S_KXP, S_DONE, S_ERR
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [IW-1:0]       r_idx, w_idx_nxt;
  logic [TW-1:0]       r_tmo, w_tmo_nxt;
  logic [CW-1:0]       r_cmkey_lat, w_cmkey_lat_nxt;
  logic [CW-1:0]       r_cmkey_out, w_cmkey_out_nxt;
  logic [KEY_W-1:0]    r_mkey, w_mkey_nxt;
  logic                r_dir, w_dir_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_ready, w_ready_nxt;
  logic                r_err, w_err_nxt;
  logic [1:0]          r_rsa_cmd, w_rsa_cmd_nxt;
  logic [CHUNK_W:0]    r_rsa_msg, w_rsa_msg_nxt;
  logic                r_kx_start, w_kx_start_nxt;
  logic                w_fail;
  logic                w_abort;
  logic [31:0]         w_kbase, w_cbase;

`ifdef ENVELOPE_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Bit offsets of the current chunk in the plain key and in the wrapped key
  assign w_kbase = 32'(r_idx) * CHUNK_W;
  assign w_cbase = 32'(r_idx) * (CHUNK_W + 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_cmkey_lat <= '0;
      r_cmkey_out <= '0;
      r_mkey      <= '0;
      r_dir       <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
      r_rsa_cmd   <= 2'b00;
      r_rsa_msg   <= '0;
      r_kx_start  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_tmo       <= w_tmo_nxt;
      r_cmkey_lat <= w_cmkey_lat_nxt;
      r_cmkey_out <= w_cmkey_out_nxt;
      r_mkey      <= w_mkey_nxt;
      r_dir       <= w_dir_nxt;
      r_busy      <= w_busy_nxt;
      r_ready     <= w_ready_nxt;
      r_err       <= w_err_nxt;
      r_rsa_cmd   <= w_rsa_cmd_nxt;
      r_rsa_msg   <= w_rsa_msg_nxt;
      r_kx_start  <= w_kx_start_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_tmo_nxt       = r_tmo;
    w_cmkey_lat_nxt = r_cmkey_lat;
    w_cmkey_out_nxt = r_cmkey_out;
    w_mkey_nxt      = r_mkey;
    w_dir_nxt       = r_dir;
    w_busy_nxt      = r_busy;
    w_ready_nxt     = 1'b0;
    w_err_nxt       = r_err;
    w_rsa_cmd_nxt   = r_rsa_cmd;
    w_rsa_msg_nxt   = r_rsa_msg;
    w_kx_start_nxt  = r_kx_start;
    w_fail          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_dir_nxt       = mode;
          w_cmkey_lat_nxt = cmkey_in;
          w_err_nxt       = 1'b0;
          w_idx_nxt       = '0;
          w_busy_nxt      = 1'b1;
          w_state_nxt     = S_LOAD;
        end
      end
      S_LOAD: begin
        w_mkey_nxt  = r_dir ? '0 : rnd_in;
        w_state_nxt = S_RSA_REQ;
      end
      S_RSA_REQ: begin
        if (r_dir) w_rsa_msg_nxt = r_cmkey_lat[w_cbase +: CHUNK_W+1];
        else       w_rsa_msg_nxt = {1'b0, r_mkey[w_kbase +: CHUNK_W]};
        w_rsa_cmd_nxt = r_dir ? 2'b10 : 2'b01;
        w_tmo_nxt     = '0;
        w_state_nxt   = S_RSA_WAIT;
      end
      S_RSA_WAIT: begin
        // A response on the expiry cycle still counts as on time
        if (rsa_rsp) begin
          w_rsa_cmd_nxt = 2'b00;
          if (r_dir && rsa_res[CHUNK_W]) begin
            w_fail = 1'b1;
          end else begin
            if (r_dir) w_mkey_nxt[w_kbase +: CHUNK_W] = rsa_res[CHUNK_W-1:0];
            else       w_cmkey_out_nxt[w_cbase +: CHUNK_W+1] = rsa_res;
            w_idx_nxt = r_idx + IW'(1);
            if (r_idx == IDX_LAST) begin
              w_kx_start_nxt = 1'b1;
              w_state_nxt    = S_KXP;
            end else begin
              w_state_nxt    = S_RSA_REQ;
            end
          end
        end else if ((TIMEOUT_CYC != 0) && (r_tmo == TMO_LAST)) begin
          w_fail = 1'b1;
        end else begin
          w_tmo_nxt = r_tmo + TW'(1);
        end
      end
      S_KXP: begin
        if (kx_done) begin
          w_kx_start_nxt = 1'b0;
          w_ready_nxt    = 1'b1;
          w_state_nxt    = S_DONE;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Error entry: release both engines and scrub all key material
    if (w_fail || (w_abort && (r_state != S_IDLE))) begin
      w_state_nxt     = S_ERR;
      w_err_nxt       = 1'b1;
      w_rsa_cmd_nxt   = 2'b00;
      w_kx_start_nxt  = 1'b0;
      w_mkey_nxt      = '0;
      w_cmkey_out_nxt = '0;
      w_ready_nxt     = 1'b0;
    end
  end

  assign cmkey_out = r_cmkey_out;
  assign mkey      = r_mkey;
  assign dir       = r_dir;
  assign busy      = r_busy;
  assign ready     = r_ready;
  assign err       = r_err;
  assign rsa_cmd   = r_rsa_cmd;
  assign rsa_msg   = r_rsa_msg;
  assign kx_start  = r_kx_start;

endmodule

// File: tb/tb_envelope_key_ctrl.sv
// Bench for envelope_key_ctrl at KEY_W=16, CHUNK_W=8, TIMEOUT_CYC=8 with stub mod-exp and
// key-expansion engines; define ENVELOPE_ABORT_EN to include the abort scenario.
module tb_envelope_key_ctrl;

  localparam int KW  = 16;
  localparam int CH  = 8;
  localparam int NC  = 2;
  localparam int CWB = 18;
  localparam int TMO = 8;

  logic           clk, rst, start, mode;
  logic [CWB-1:0] cmkey_in, cmkey_out;
  logic [KW-1:0]  rnd_in, mkey;
  logic           dir, busy, ready, err;
  logic [1:0]     rsa_cmd;
  logic [CH:0]    rsa_msg, rsa_res;
  logic           rsa_rsp, kx_start, kx_done;
`ifdef ENVELOPE_ABORT_EN
  logic           abort;
`endif

  envelope_key_ctrl #(.KEY_W(KW), .CHUNK_W(CH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
`ifdef ENVELOPE_ABORT_EN
    .abort(abort),
`endif
    .start(start), .mode(mode), .cmkey_in(cmkey_in), .rnd_in(rnd_in),
    .cmkey_out(cmkey_out), .mkey(mkey), .dir(dir), .busy(busy), .ready(ready), .err(err),
    .rsa_cmd(rsa_cmd), .rsa_msg(rsa_msg), .rsa_res(rsa_res), .rsa_rsp(rsa_rsp),
    .kx_start(kx_start), .kx_done(kx_done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Expected state, owned by the model
  logic [KW-1:0]  exp_mkey = '0;
  logic [CWB-1:0] exp_cmkey = '0;
  logic           exp_dir = 1'b0;
  logic           exp_err = 1'b0;
  logic [1:0]     exp_cmd = 2'b00;
  logic [CH:0]    exp_msg [NC];
  int             exp_ready = 0;
  int             exp_reqs = 0;
  bit             chk_en = 1'b0;

  // Stub configuration and observations
  int  st_lat = 3;     // 0 = never respond
  bit  st_dec = 1'b0;  // 0: res = msg+1, 1: res = msg-1
  int  st_bad = -1;    // chunk that answers 9'h1FF
  int  req_n = 0;
  int  n_ready = 0;
  int  last_req_cyc = 0;
  int  err_rise_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc = cyc + 1; end

  // Stub mod-exp engine: one answer per new request, st_lat cycles after it appears
  int          r_cnt = 0;
  int          r_idx = 0;
  logic [1:0]  r_prev = 2'b00;
  logic [CH:0] r_pmsg = '0;
  initial begin
    rsa_rsp = 1'b0;
    rsa_res = '0;
    forever begin
      @(negedge clk);
      rsa_rsp = 1'b0;
      if (rsa_cmd != 2'b00 && r_prev == 2'b00) begin
        if (req_n < NC) begin
          check("rsa_msg", 64'(rsa_msg), 64'(exp_msg[req_n]));
          check("rsa_cmd", 64'(rsa_cmd), 64'(exp_cmd));
        end
        r_idx = req_n;
        req_n++;
        last_req_cyc = cyc;
        r_pmsg = rsa_msg;
        r_cnt = st_lat;
      end
      r_prev = rsa_cmd;
      if (r_cnt > 0) begin
        r_cnt--;
        if (r_cnt == 0) begin
          rsa_rsp = 1'b1;
          rsa_res = (r_idx == st_bad) ? 9'h1FF : (st_dec ? r_pmsg - 9'd1 : r_pmsg + 9'd1);
        end
      end
    end
  end

  // Stub key expansion: kx_done pulses two cycles after kx_start rises
  int   k_cnt = 0;
  logic k_prev = 1'b0;
  initial begin
    kx_done = 1'b0;
    forever begin
      @(negedge clk);
      kx_done = 1'b0;
      if (kx_start && !k_prev) k_cnt = 2;
      k_prev = kx_start;
      if (k_cnt > 0) begin
        k_cnt--;
        if (k_cnt == 0) kx_done = 1'b1;
      end
    end
  end

  // Compare process: whenever idle, the held results must match the model
  logic prev_err = 1'b0;
  initial forever begin
    @(negedge clk);
    if (ready) n_ready++;
    if (err && !prev_err) err_rise_cyc = cyc;
    prev_err = err;
    if (chk_en && !busy) begin
      check("idle_mkey", 64'(mkey), 64'(exp_mkey));
      check("idle_cmkey_out", 64'(cmkey_out), 64'(exp_cmkey));
      check("idle_dir", 64'(dir), 64'(exp_dir));
      check("idle_err", 64'(err), 64'(exp_err));
      check("idle_rsa_cmd", 64'(rsa_cmd), 64'd0);
      check("idle_kx_start", 64'(kx_start), 64'd0);
    end
  end

  // Model: what one operation must leave behind, from chunk arithmetic alone
  task automatic model(input bit md, input logic [KW-1:0] rnd, input logic [CWB-1:0] cm);
    logic [KW-1:0]  key;
    logic [CWB-1:0] ck;
    logic [CH:0]    msg, res;
    bit             bad;
    bad = 1'b0;
    key = md ? '0 : rnd;
    ck = exp_cmkey;
    exp_reqs = 0;
    exp_cmd = md ? 2'b10 : 2'b01;
    for (int i = 0; i < NC; i++) begin
      msg = md ? cm[i*(CH+1) +: CH+1] : {1'b0, key[i*CH +: CH]};
      exp_msg[i] = msg;
      exp_reqs++;
      if (st_lat == 0 || st_lat > TMO) begin bad = 1'b1; break; end
      res = (i == st_bad) ? 9'h1FF : (st_dec ? msg - 9'd1 : msg + 9'd1);
      if (!md) ck[i*(CH+1) +: CH+1] = res;
      else if (res[CH]) begin bad = 1'b1; break; end
      else key[i*CH +: CH] = res[CH-1:0];
    end
    exp_dir   = md;
    exp_err   = bad;
    exp_ready = bad ? 0 : 1;
    exp_mkey  = bad ? '0 : key;
    exp_cmkey = bad ? '0 : ck;
  endtask

  // action: 0 plain, 1 spurious start mid-wait, 2 abort with kx_done, 3 rst during KXP
  task automatic run_op(input bit md, input logic [KW-1:0] rnd, input logic [CWB-1:0] cm,
                        input int lat, input bit dec_fn, input int bad, input int action);
    int guard;
    bit spur, rdone;
    spur = 1'b0; rdone = 1'b0; guard = 0;
    @(negedge clk);
    chk_en = 1'b0;
    st_lat = lat; st_dec = dec_fn; st_bad = bad;
    req_n = 0; n_ready = 0;
    model(md, rnd, cm);
    if (action == 2) begin
      exp_err = 1'b1; exp_mkey = '0; exp_cmkey = '0; exp_ready = 0;
    end
    if (action == 3) begin
      exp_err = 1'b0; exp_mkey = '0; exp_cmkey = '0; exp_ready = 0; exp_dir = 1'b0;
    end
    start = 1'b1; mode = md; rnd_in = rnd; cmkey_in = cm;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("err_cleared_by_start", 64'(err), 64'd0);
    while (busy && guard < 400) begin
      if (action == 1 && !spur && rsa_cmd != 2'b00) begin
        start = 1'b1; mode = ~md; cmkey_in = ~cm; rnd_in = ~rnd; spur = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (action == 3 && !rdone && kx_start) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; rdone = 1'b1;
        check("rst_kx_start", 64'(kx_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mkey", 64'(mkey), 64'd0);
        check("rst_cmkey_out", 64'(cmkey_out), 64'd0);
        check("rst_dir", 64'(dir), 64'd0);
        check("rst_err_ready", 64'({err, ready}), 64'd0);
        check("rst_rsa", 64'({rsa_cmd, rsa_msg}), 64'd0);
      end
      @(negedge clk);
`ifdef ENVELOPE_ABORT_EN
      if (action == 2) begin #1; abort = kx_done; end
`endif
      guard++;
    end
    start = 1'b0;
`ifdef ENVELOPE_ABORT_EN
    abort = 1'b0;
`endif
    if (busy) check("op_completion_bound", 64'(busy), 64'd0);
    check("ready_pulses", 64'(n_ready), 64'(exp_ready));
    check("rsa_requests", 64'(req_n), 64'(exp_reqs));
    chk_en = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  logic [CWB-1:0] wrapped;

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; cmkey_in = '0; rnd_in = '0;
`ifdef ENVELOPE_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_outputs_key", 64'({mkey, cmkey_out}), 64'd0);
    check("reset_outputs_ctl", 64'({dir, busy, ready, err, rsa_cmd, kx_start}), 64'd0);
    check("reset_rsa_msg", 64'(rsa_msg), 64'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Encrypt A55A, stub +1 after 3 cycles
    run_op(1'b0, 16'hA55A, '0, 3, 1'b0, -1, 0);
    wrapped = {9'h0A6, 9'h05B};
    check("enc_mkey_literal", 64'(mkey), 64'h0000_0000_0000_A55A);
    check("enc_cmkey_literal", 64'(cmkey_out), 64'(wrapped));

    // Decrypt the same wrapped key, stub -1
    run_op(1'b1, 16'h0000, wrapped, 3, 1'b1, -1, 0);
    check("dec_mkey_literal", 64'(mkey), 64'h0000_0000_0000_A55A);
    check("dec_dir_literal", 64'(dir), 64'd1);

    // Decrypt with out-of-range result on chunk 0
    run_op(1'b1, 16'h0000, wrapped, 3, 1'b1, 0, 0);
    check("range_err_literal", 64'({err, mkey}), 64'h1_0000);

    // Response exactly on the timeout cycle wins
    run_op(1'b0, 16'h1234, '0, 8, 1'b0, -1, 0);
    check("tmo_edge_err_literal", 64'(err), 64'd0);

    // Silent engine times out after 8 wait cycles
    run_op(1'b0, 16'h1234, '0, 0, 1'b0, -1, 0);
    check("tmo_cycles_literal", 64'(err_rise_cyc - last_req_cyc), 64'd8);

    // One cycle too late
    run_op(1'b0, 16'h4321, '0, 9, 1'b0, -1, 0);

    // Spurious start mid-wait, chunk value at the top of its range
    run_op(1'b0, 16'h00FF, '0, 1, 1'b0, -1, 1);
    wrapped = {9'h001, 9'h100};
    check("spur_cmkey_literal", 64'(cmkey_out), 64'(wrapped));

    // Out-of-range result on the last chunk
    run_op(1'b1, 16'h0000, {9'h0A6, 9'h05B}, 2, 1'b1, 1, 0);

    // Good decrypt after an error
    run_op(1'b1, 16'h0000, {9'h011, 9'h0FF}, 4, 1'b1, -1, 0);
    check("dec2_mkey_literal", 64'(mkey), 64'h0000_0000_0000_10FE);

    // Reset while in key expansion
    run_op(1'b0, 16'hBEEF, '0, 2, 1'b0, -1, 3);

`ifdef ENVELOPE_ABORT_EN
    // Abort in the same cycle as kx_done
    run_op(1'b0, 16'hC3C3, '0, 3, 1'b0, -1, 2);
    check("abort_err_literal", 64'({err, mkey}), 64'h1_0000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

endmodule
